// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory stage: widths, opcodes, MMIO addresses, FSM states and
// condition-code helpers.
package memory_stage_pkg;

    localparam int REG_WIDTH    = 16;
    localparam int PC_WIDTH     = 16;
    localparam int OPCODE_WIDTH = 8;

    localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = 8'h00;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 8'h01;
    localparam logic [OPCODE_WIDTH-1:0] OP_AND   = 8'h02;
    localparam logic [OPCODE_WIDTH-1:0] OP_ANDI  = 8'h03;
    localparam logic [OPCODE_WIDTH-1:0] OP_MOV   = 8'h04;
    localparam logic [OPCODE_WIDTH-1:0] OP_MOVI  = 8'h05;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDW   = 8'h10;
    localparam logic [OPCODE_WIDTH-1:0] OP_STW   = 8'h11;
    // Branch opcodes carry their {N,Z,P} mask in the low three bits.
    localparam logic [OPCODE_WIDTH-1:0] OP_BRP   = 8'h21;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRZ   = 8'h22;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRZP  = 8'h23;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRN   = 8'h24;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRNP  = 8'h25;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRNZ  = 8'h26;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRNZP = 8'h27;
    localparam logic [OPCODE_WIDTH-1:0] OP_JSR   = 8'h30;
    localparam logic [OPCODE_WIDTH-1:0] OP_NOP   = 8'hFF;

    localparam logic [REG_WIDTH-1:0] MMIO_LEDR_ADDR = 16'hFFF0;
    localparam logic [REG_WIDTH-1:0] MMIO_HEX_ADDR  = 16'hFFF2;
    localparam logic [REG_WIDTH-1:0] MMIO_SW_ADDR   = 16'hFFF4;

    localparam logic [2:0] NZP_Z = 3'b010;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    function automatic logic [2:0] nzp_of(input logic [REG_WIDTH-1:0] v);
        logic [2:0] r;
        if (v[REG_WIDTH-1]) r = 3'b100;
        else if (v == {REG_WIDTH{1'b0}}) r = 3'b010;
        else r = 3'b001;
        return r;
    endfunction

    function automatic logic [2:0] branch_mask(input logic [OPCODE_WIDTH-1:0] op);
        logic [2:0] m;
        if (op[OPCODE_WIDTH-1:3] == 5'b00100) m = op[2:0];
        else m = 3'b000;
        return m;
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Execute -> memory pipeline bundle; master is the Execute side, slave is the memory stage.
interface memory_stage_if;
    import memory_stage_pkg::*;

    logic                    I_LOCK;
    logic [REG_WIDTH-1:0]    I_ALUOut;
    logic [OPCODE_WIDTH-1:0] I_Opcode;
    logic [3:0]              I_DestRegIdx;
    logic [REG_WIDTH-1:0]    I_DestValue;
    logic                    I_FetchStall;
    logic                    I_DepStall;
    logic                    O_LOCK;
    logic [OPCODE_WIDTH-1:0] O_Opcode;
    logic [3:0]              O_DestRegIdx;
    logic [REG_WIDTH-1:0]    O_DestValue;
    logic                    O_RegWrEn;
    logic                    O_BranchTaken;
    logic [PC_WIDTH-1:0]     O_BranchPC;
    logic                    O_MemStall;
    logic                    O_FetchStall;
    logic                    O_DepStall;

    modport master (
        output I_LOCK, I_ALUOut, I_Opcode, I_DestRegIdx, I_DestValue, I_FetchStall, I_DepStall,
        input  O_LOCK, O_Opcode, O_DestRegIdx, O_DestValue, O_RegWrEn, O_BranchTaken, O_BranchPC,
               O_MemStall, O_FetchStall, O_DepStall
    );

    modport slave (
        input  I_LOCK, I_ALUOut, I_Opcode, I_DestRegIdx, I_DestValue, I_FetchStall, I_DepStall,
        output O_LOCK, O_Opcode, O_DestRegIdx, O_DestValue, O_RegWrEn, O_BranchTaken, O_BranchPC,
               O_MemStall, O_FetchStall, O_DepStall
    );

endinterface

// File: rtl/memory_stage_dmem_ram.sv
// Private data RAM: synchronous write, registered read with enable; updates on the falling edge
// to match the rest of the memory stage. Contents are not reset.
module dmem_ram #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_rdata;

    // Write port and read register; read data holds until the next enabled read.
    always_ff @(negedge i_clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/memory_stage.sv
// Memory stage: LDW/STW with DMEM_WAIT wait states, NZP branch resolution, writeback.
// Optional MMIO (LEDR/HEX/SW) is enabled by defining MEM_MMIO_EN.
module memory_stage #(
    parameter int DMEM_DEPTH = 1024,
    parameter int DMEM_WAIT  = 2
) (
    memory_stage_if.slave bus,
    input  logic          I_CLOCK,
    input  logic          I_RESET_N
`ifdef MEM_MMIO_EN
    ,
    input  logic [9:0]    I_SW,
    output logic [9:0]    O_LEDR,
    output logic [15:0]   O_HEX
`endif
);
    import memory_stage_pkg::*;

    localparam int         AW        = $clog2(DMEM_DEPTH);
    localparam bit         HAS_WAIT  = (DMEM_WAIT > 0);
    localparam logic [2:0] WAIT_INIT = HAS_WAIT ? 3'(DMEM_WAIT - 1) : 3'd0;

    mem_state_e              r_state;
    logic [2:0]              r_cnt;
    logic [OPCODE_WIDTH-1:0] r_lat_op;
    logic [REG_WIDTH-1:0]    r_lat_alu;
    logic [REG_WIDTH-1:0]    r_lat_val;
    logic [2:0]              r_nzp;
    logic                    r_nzp_ram;
    logic                    r_sel_ram;
    logic                    r_lock, r_regwr, r_taken, r_mem_stall, r_fs, r_ds;
    logic [OPCODE_WIDTH-1:0] r_opcode;
    logic [3:0]              r_idx;
    logic [REG_WIDTH-1:0]    r_dest;
    logic [PC_WIDTH-1:0]     r_bpc;
`ifdef MEM_MMIO_EN
    logic [9:0]              r_ledr;
    logic [15:0]             r_hex;
`endif

    logic                    w_live, w_is_mem, w_mmio, w_start_wait, w_do, w_ram_we, w_ram_re;
    logic [OPCODE_WIDTH-1:0] w_op;
    logic [REG_WIDTH-1:0]    w_alu, w_val, w_ram_q;
    logic [2:0]              w_nzp;

    // Operand selection (latched copy during WAIT) and access-completion decode.
    always_comb begin
        w_live = bus.I_LOCK & ~bus.I_FetchStall & ~bus.I_DepStall;
        if (r_state == ST_WAIT) begin
            w_op  = r_lat_op;
            w_alu = r_lat_alu;
            w_val = r_lat_val;
        end else begin
            w_op  = bus.I_Opcode;
            w_alu = bus.I_ALUOut;
            w_val = bus.I_DestValue;
        end
        w_is_mem = (w_op == OP_LDW) || (w_op == OP_STW);
`ifdef MEM_MMIO_EN
        w_mmio = ((w_op == OP_STW) && ((w_alu == MMIO_LEDR_ADDR) || (w_alu == MMIO_HEX_ADDR))) ||
                 ((w_op == OP_LDW) && (w_alu == MMIO_SW_ADDR));
`else
        w_mmio = 1'b0;
`endif
        w_start_wait = (r_state == ST_IDLE) && w_live && w_is_mem && !w_mmio && HAS_WAIT;
        if (r_state == ST_WAIT) w_do = (r_cnt == 3'd0);
        else if (w_live) w_do = !w_start_wait;
        else w_do = 1'b0;
        // Gate the write with reset so an aborted access never reaches the array.
        w_ram_we = I_RESET_N && w_do && (w_op == OP_STW) && !w_mmio;
        w_ram_re = w_do && (w_op == OP_LDW) && !w_mmio;
        w_nzp    = r_nzp_ram ? nzp_of(w_ram_q) : r_nzp;
    end

    dmem_ram #(.AW(AW), .DW(REG_WIDTH)) u_dmem_ram (
        .i_clk   (I_CLOCK),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_alu[AW-1:0]),
        .i_wdata (w_val),
        .o_rdata (w_ram_q)
    );

    // Wait-state FSM, condition codes and registered writeback/branch outputs.
    always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 3'd0;
            r_lat_op    <= {OPCODE_WIDTH{1'b0}};
            r_lat_alu   <= {REG_WIDTH{1'b0}};
            r_lat_val   <= {REG_WIDTH{1'b0}};
            r_nzp       <= NZP_Z;
            r_nzp_ram   <= 1'b0;
            r_sel_ram   <= 1'b0;
            r_lock      <= 1'b0;
            r_regwr     <= 1'b0;
            r_taken     <= 1'b0;
            r_mem_stall <= 1'b0;
            r_fs        <= 1'b0;
            r_ds        <= 1'b0;
            r_opcode    <= {OPCODE_WIDTH{1'b0}};
            r_idx       <= 4'd0;
            r_dest      <= {REG_WIDTH{1'b0}};
            r_bpc       <= {PC_WIDTH{1'b0}};
`ifdef MEM_MMIO_EN
            r_ledr      <= 10'd0;
            r_hex       <= 16'd0;
`endif
        end else begin
            r_lock   <= bus.I_LOCK;
            r_opcode <= bus.I_Opcode;
            r_idx    <= bus.I_DestRegIdx;
            r_fs     <= bus.I_FetchStall;
            r_ds     <= bus.I_DepStall;
            r_regwr  <= 1'b0;
            r_taken  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_wait) begin
                        r_state     <= ST_WAIT;
                        r_cnt       <= WAIT_INIT;
                        r_mem_stall <= 1'b1;
                        r_lat_op    <= bus.I_Opcode;
                        r_lat_alu   <= bus.I_ALUOut;
                        r_lat_val   <= bus.I_DestValue;
                    end else begin
                        r_mem_stall <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt != 3'd0) begin
                        r_cnt <= r_cnt - 3'd1;
                    end else begin
                        r_state     <= ST_IDLE;
                        r_mem_stall <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_do) begin
                case (w_op)
                    OP_ADD, OP_ADDI, OP_AND, OP_ANDI, OP_MOV, OP_MOVI: begin
                        r_dest    <= w_alu;
                        r_regwr   <= 1'b1;
                        r_sel_ram <= 1'b0;
                        r_nzp     <= nzp_of(w_alu);
                        r_nzp_ram <= 1'b0;
                    end
                    OP_LDW: begin
                        r_regwr <= 1'b1;
`ifdef MEM_MMIO_EN
                        if (w_alu == MMIO_SW_ADDR) begin
                            r_dest    <= {6'b000000, I_SW};
                            r_sel_ram <= 1'b0;
                            r_nzp     <= nzp_of({6'b000000, I_SW});
                            r_nzp_ram <= 1'b0;
                        end else begin
                            r_sel_ram <= 1'b1;
                            r_nzp_ram <= 1'b1;
                        end
`else
                        r_sel_ram <= 1'b1;
                        r_nzp_ram <= 1'b1;
`endif
                    end
                    OP_STW: begin
`ifdef MEM_MMIO_EN
                        if (w_alu == MMIO_LEDR_ADDR) r_ledr <= w_val[9:0];
                        else if (w_alu == MMIO_HEX_ADDR) r_hex <= w_val;
                        else r_hex <= r_hex;
`endif
                    end
                    OP_JSR: begin
                        r_taken   <= 1'b1;
                        r_bpc     <= w_alu;
                        r_dest    <= w_val;
                        r_sel_ram <= 1'b0;
                        r_regwr   <= 1'b1;
                    end
                    default: begin
                        if ((branch_mask(w_op) & w_nzp) != 3'b000) begin
                            r_taken <= 1'b1;
                            r_bpc   <= w_alu;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.O_LOCK        = r_lock;
    assign bus.O_Opcode      = r_opcode;
    assign bus.O_DestRegIdx  = r_idx;
    assign bus.O_DestValue   = r_sel_ram ? w_ram_q : r_dest;
    assign bus.O_RegWrEn     = r_regwr;
    assign bus.O_BranchTaken = r_taken;
    assign bus.O_BranchPC    = r_bpc;
    assign bus.O_MemStall    = r_mem_stall;
    assign bus.O_FetchStall  = r_fs;
    assign bus.O_DepStall    = r_ds;
`ifdef MEM_MMIO_EN
    assign O_LEDR = r_ledr;
    assign O_HEX  = r_hex;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench: one instance with DMEM_WAIT=0 and one with DMEM_WAIT=2 share the stimulus;
// only the selected instance sees a live slot. MMIO steps run when MEM_MMIO_EN is defined.
module tb_memory_stage;
    import memory_stage_pkg::*;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   we_cnt;
    int   we_base;
    int   tgt;

    logic [7:0]  s_op;
    logic [15:0] s_alu;
    logic [15:0] s_val;
    logic [3:0]  s_idx;
    logic        s_lock, s_fs, s_ds;
`ifdef MEM_MMIO_EN
    logic [9:0]  s_sw;
    logic [9:0]  ledr0, ledr2;
    logic [15:0] hex0, hex2;
`endif

    memory_stage_if if0 ();
    memory_stage_if if2 ();

    assign if0.I_LOCK       = (tgt == 0) ? s_lock : 1'b0;
    assign if0.I_ALUOut     = s_alu;
    assign if0.I_Opcode     = s_op;
    assign if0.I_DestRegIdx = s_idx;
    assign if0.I_DestValue  = s_val;
    assign if0.I_FetchStall = s_fs;
    assign if0.I_DepStall   = s_ds;
    assign if2.I_LOCK       = (tgt == 2) ? s_lock : 1'b0;
    assign if2.I_ALUOut     = s_alu;
    assign if2.I_Opcode     = s_op;
    assign if2.I_DestRegIdx = s_idx;
    assign if2.I_DestValue  = s_val;
    assign if2.I_FetchStall = s_fs;
    assign if2.I_DepStall   = s_ds;

    memory_stage #(.DMEM_DEPTH(1024), .DMEM_WAIT(0)) u_dut0 (
        .bus(if0), .I_CLOCK(clk), .I_RESET_N(rst_n)
`ifdef MEM_MMIO_EN
        , .I_SW(s_sw), .O_LEDR(ledr0), .O_HEX(hex0)
`endif
    );

    memory_stage #(.DMEM_DEPTH(1024), .DMEM_WAIT(2)) u_dut2 (
        .bus(if2), .I_CLOCK(clk), .I_RESET_N(rst_n)
`ifdef MEM_MMIO_EN
        , .I_SW(s_sw), .O_LEDR(ledr2), .O_HEX(hex2)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count RAM write strobes of the wait-state instance, sampled mid-cycle.
    always @(posedge clk) begin
        if (u_dut2.w_ram_we) we_cnt <= we_cnt + 1;
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [15:0] alu, input logic [15:0] val,
                         input logic [3:0] idx, input logic fs, input logic ds);
        s_op   = op;
        s_alu  = alu;
        s_val  = val;
        s_idx  = idx;
        s_lock = 1'b1;
        s_fs   = fs;
        s_ds   = ds;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0; we_cnt = 0; tgt = 0;
        rst_n = 1'b0;
        s_op = OP_NOP; s_alu = 16'h0000; s_val = 16'h0000; s_idx = 4'd0;
        s_lock = 1'b0; s_fs = 1'b0; s_ds = 1'b0;
`ifdef MEM_MMIO_EN
        s_sw = 10'd0;
`endif
        tick; tick;
        chk("rst_destvalue", if0.O_DestValue, 32'h0);
        chk("rst_regwr", if0.O_RegWrEn, 32'h0);
        chk("rst_taken", if2.O_BranchTaken, 32'h0);
        chk("rst_memstall", if2.O_MemStall, 32'h0);
        rst_n = 1'b1;

        // DMEM_WAIT=0: store then load, plus address wrap.
        drive(OP_STW, 16'h0005, 16'h1234, 4'd1, 1'b0, 1'b0); tick;
        chk("w0_stw_regwr", if0.O_RegWrEn, 32'h0);
        chk("w0_stw_opcode", if0.O_Opcode, 32'(OP_STW));
        drive(OP_LDW, 16'h0005, 16'h0000, 4'd2, 1'b0, 1'b0); tick;
        chk("w0_ldw_data", if0.O_DestValue, 32'h1234);
        chk("w0_ldw_regwr", if0.O_RegWrEn, 32'h1);
        chk("w0_ldw_idx", if0.O_DestRegIdx, 32'h2);
        chk("w0_ldw_nostall", if0.O_MemStall, 32'h0);
        drive(OP_LDW, 16'h0405, 16'h0000, 4'd3, 1'b0, 1'b0); tick;
        chk("w0_ldw_wrap", if0.O_DestValue, 32'h1234);
        drive(OP_BRP, 16'h0100, 16'h0000, 4'd0, 1'b0, 1'b0); tick;
        chk("brp_after_load_taken", if0.O_BranchTaken, 32'h1);
        chk("brp_pc", if0.O_BranchPC, 32'h0100);
        s_lock = 1'b0; s_op = OP_NOP; tick;
        chk("taken_one_pulse", if0.O_BranchTaken, 32'h0);

        // Negative result and branches.
        drive(OP_MOVI, 16'hFFFF, 16'h0000, 4'd4, 1'b0, 1'b0); tick;
        chk("movi_value", if0.O_DestValue, 32'hFFFF);
        chk("movi_regwr", if0.O_RegWrEn, 32'h1);
        drive(OP_BRN, 16'h0040, 16'h0000, 4'd0, 1'b0, 1'b0); tick;
        chk("brn_taken", if0.O_BranchTaken, 32'h1);
        chk("brn_pc", if0.O_BranchPC, 32'h0040);
        chk("brn_regwr", if0.O_RegWrEn, 32'h0);
        drive(OP_BRZ, 16'h0080, 16'h0000, 4'd0, 1'b0, 1'b0); tick;
        chk("brz_not_taken", if0.O_BranchTaken, 32'h0);

        // Dead slots and JSR.
        drive(OP_STW, 16'h0009, 16'h5555, 4'd0, 1'b0, 1'b0); tick;
        drive(OP_STW, 16'h0009, 16'hBEEF, 4'd0, 1'b0, 1'b1); tick;
        chk("dep_stw_regwr", if0.O_RegWrEn, 32'h0);
        chk("dep_flag_pass", if0.O_DepStall, 32'h1);
        drive(OP_MOVI, 16'h0000, 16'h0000, 4'd5, 1'b1, 1'b0); tick;
        chk("fetch_bubble_regwr", if0.O_RegWrEn, 32'h0);
        chk("fetch_flag_pass", if0.O_FetchStall, 32'h1);
        drive(OP_LDW, 16'h0009, 16'h0000, 4'd6, 1'b0, 1'b0); tick;
        chk("dep_stw_no_store", if0.O_DestValue, 32'h5555);
        drive(OP_MOVI, 16'h8000, 16'h0000, 4'd6, 1'b0, 1'b0); tick;
        drive(OP_JSR, 16'h0200, 16'h0011, 4'd7, 1'b0, 1'b0); tick;
        chk("jsr_taken", if0.O_BranchTaken, 32'h1);
        chk("jsr_pc", if0.O_BranchPC, 32'h0200);
        chk("jsr_link", if0.O_DestValue, 32'h0011);
        chk("jsr_regwr", if0.O_RegWrEn, 32'h1);
        drive(OP_BRN, 16'h0044, 16'h0000, 4'd0, 1'b0, 1'b0); tick;
        chk("jsr_nzp_held", if0.O_BranchTaken, 32'h1);

        // DMEM_WAIT=2: three-edge store and load, back to back.
        tgt = 2;
        we_base = we_cnt;
        drive(OP_STW, 16'h0003, 16'hA5A5, 4'd0, 1'b0, 1'b0); tick;
        chk("w2_stw_e1_stall", if2.O_MemStall, 32'h1);
        tick;
        chk("w2_stw_e2_stall", if2.O_MemStall, 32'h1);
        tick;
        chk("w2_stw_e3_stall", if2.O_MemStall, 32'h0);
        chk("w2_single_store", 32'(we_cnt - we_base), 32'h1);
        drive(OP_LDW, 16'h0003, 16'h0000, 4'd4, 1'b0, 1'b0); tick;
        chk("w2_ldw_e1_stall", if2.O_MemStall, 32'h1);
        chk("w2_ldw_e1_regwr", if2.O_RegWrEn, 32'h0);
        tick;
        chk("w2_ldw_e2_stall", if2.O_MemStall, 32'h1);
        tick;
        chk("w2_ldw_e3_stall", if2.O_MemStall, 32'h0);
        chk("w2_ldw_e3_regwr", if2.O_RegWrEn, 32'h1);
        chk("w2_ldw_e3_data", if2.O_DestValue, 32'hA5A5);

        // Reset in the middle of a waited store.
        drive(OP_STW, 16'h0007, 16'h1111, 4'd0, 1'b0, 1'b0); tick; tick; tick;
        we_base = we_cnt;
        drive(OP_STW, 16'h0007, 16'h7777, 4'd0, 1'b0, 1'b0); tick;
        chk("abort_e1_stall", if2.O_MemStall, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_stall_cleared", if2.O_MemStall, 32'h0);
        chk("abort_lock_cleared", if2.O_LOCK, 32'h0);
        s_lock = 1'b0; s_op = OP_NOP;
        tick;
        rst_n = 1'b1;
        chk("abort_no_strobe", 32'(we_cnt - we_base), 32'h0);
        drive(OP_BRZ, 16'h0060, 16'h0000, 4'd0, 1'b0, 1'b0); tick;
        chk("abort_nzp_z", if2.O_BranchTaken, 32'h1);
        drive(OP_LDW, 16'h0007, 16'h0000, 4'd1, 1'b0, 1'b0); tick; tick; tick;
        chk("abort_ram_kept", if2.O_DestValue, 32'h1111);

`ifdef MEM_MMIO_EN
        drive(OP_STW, 16'hFFF0, 16'h03FF, 4'd0, 1'b0, 1'b0); tick;
        chk("mmio_ledr", ledr2, 32'h3FF);
        chk("mmio_stw_nostall", if2.O_MemStall, 32'h0);
        drive(OP_STW, 16'hFFF2, 16'hC0DE, 4'd0, 1'b0, 1'b0); tick;
        chk("mmio_hex", hex2, 32'hC0DE);
        s_sw = 10'h02A;
        drive(OP_LDW, 16'hFFF4, 16'h0000, 4'd2, 1'b0, 1'b0); tick;
        chk("mmio_sw_data", if2.O_DestValue, 32'h002A);
        chk("mmio_sw_regwr", if2.O_RegWrEn, 32'h1);
        chk("mmio_ldw_nostall", if2.O_MemStall, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
